// File: rtl/cam_ctrl.sv
// cam_ctrl: camera bring-up FSM (power-up wait, configuration with retry) and FIFO-to-stream pixel framer.
module cam_ctrl #(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int PWRUP_CYCLES = 100000,
  parameter int CFG_TIMEOUT  = 2000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        o_cfg_init,
  input  logic        i_cfg_done,
  input  logic        i_sof,
  output logic        o_obuf_rd,
  input  logic [15:0] i_obuf_data,
  input  logic        i_obuf_empty,
  output logic        o_pix_valid,
  input  logic        i_pix_ready,
  output logic [15:0] o_pix_data,
  output logic        o_pix_sof,
  output logic        o_pix_eol,
  output logic        o_pix_eof,
  output logic [15:0] o_frame_cnt,
  output logic        o_frame_err,
  output logic        o_cfg_err,
  output logic [2:0]  o_state
);
  localparam int CW = $clog2((PWRUP_CYCLES > CFG_TIMEOUT ? PWRUP_CYCLES : CFG_TIMEOUT) + 1);
  localparam int AW = $clog2(MAX_RETRY + 1);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  typedef enum logic [2:0] {PWRUP = 3'd0, CFG = 3'd1, WAIT_SOF = 3'd2, STREAM = 3'd3, ERROR = 3'd4} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [AW-1:0] att;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic s1, s2, s3, sof_ev, rd_pend, accept, timeout, last_x, last_y, restart;
  assign sof_ev     = s2 & ~s3;
  assign accept     = o_pix_valid & i_pix_ready;
  assign timeout    = state == CFG && cnt == CW'(CFG_TIMEOUT);
  assign last_x     = x == XW'(IMG_W - 1);
  assign last_y     = y == YW'(IMG_H - 1);
  assign restart    = sof_ev && (state == WAIT_SOF || state == STREAM);
  assign o_state    = state;
  assign o_cfg_init = state == CFG && cnt == '0;
  assign o_cfg_err  = state == ERROR;
  // In STREAM a read is only issued when its word is guaranteed a slot, never on an SOF or the final accept
  assign o_obuf_rd  = state == WAIT_SOF ? !i_obuf_empty :
                      state == STREAM && !i_obuf_empty && !rd_pend && !sof_ev &&
                      (!o_pix_valid || (i_pix_ready && !o_pix_eof));
  always_comb begin
    state_nx = state;
    case (state)
      PWRUP:    state_nx = cnt == CW'(PWRUP_CYCLES - 1) ? CFG : PWRUP;
      CFG:      state_nx = i_cfg_done ? WAIT_SOF : (timeout && att == AW'(MAX_RETRY - 1)) ? ERROR : CFG;
      WAIT_SOF: state_nx = sof_ev ? STREAM : WAIT_SOF;
      STREAM:   state_nx = (!sof_ev && accept && o_pix_eof) ? WAIT_SOF : STREAM;
      default:  state_nx = state;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= PWRUP;
      cnt   <= '0;
      att   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state || timeout || !(state == PWRUP || state == CFG)) ? '0 : cnt + 1'b1;
      att   <= state != CFG ? '0 : timeout ? att + 1'b1 : att;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      {s1, s2, s3} <= '0;
      rd_pend      <= 1'b0;
      x            <= '0;
      y            <= '0;
      o_pix_valid  <= 1'b0;
      o_pix_data   <= '0;
      o_pix_sof    <= 1'b0;
      o_pix_eol    <= 1'b0;
      o_pix_eof    <= 1'b0;
      o_frame_cnt  <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      s1      <= i_sof;
      s2      <= s1;
      s3      <= s2;
      rd_pend <= state == STREAM && o_obuf_rd;
      if (state == STREAM && sof_ev) o_frame_err <= 1'b1;
      if (restart) begin
        x           <= '0;
        y           <= '0;
        o_pix_valid <= 1'b0;
        {o_pix_sof, o_pix_eol, o_pix_eof} <= '0;
      end else if (rd_pend) begin
        o_pix_valid <= 1'b1;
        o_pix_data  <= i_obuf_data;
        o_pix_sof   <= x == '0 && y == '0;
        o_pix_eol   <= last_x;
        o_pix_eof   <= last_x && last_y;
      end else if (accept) begin
        o_pix_valid <= 1'b0;
        {o_pix_sof, o_pix_eol, o_pix_eof} <= '0;
        x           <= last_x ? '0 : x + 1'b1;
        y           <= last_x ? (last_y ? '0 : y + 1'b1) : y;
        if (o_pix_eof) o_frame_cnt <= o_frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: random and directed checks of cam_ctrl against a queue-based frame scoreboard.
module tb_cam_ctrl;
  localparam int W = 4, H = 2, N = W * H;
  logic        i_clk = 0, i_rstn = 0, i_cfg_done = 0, i_sof = 0, i_obuf_empty = 1, i_pix_ready = 0;
  logic [15:0] i_obuf_data = '0;
  logic        o_cfg_init, o_obuf_rd, o_pix_valid, o_pix_sof, o_pix_eol, o_pix_eof, o_frame_err, o_cfg_err;
  logic [15:0] o_pix_data, o_frame_cnt;
  logic [2:0]  o_state;
  int total = 0, bad = 0;
  logic [15:0] fifo_q[$], exp_q[$];
  int pos = 0, frames = 0, beats = 0;
  bit chk_hold = 1, prev_hold = 0, prev_acc = 0;
  logic [15:0] prev_data;

  cam_ctrl #(.IMG_W(W), .IMG_H(H), .PWRUP_CYCLES(10), .CFG_TIMEOUT(20), .MAX_RETRY(3)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .o_cfg_init(o_cfg_init), .i_cfg_done(i_cfg_done), .i_sof(i_sof),
    .o_obuf_rd(o_obuf_rd), .i_obuf_data(i_obuf_data), .i_obuf_empty(i_obuf_empty),
    .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready), .o_pix_data(o_pix_data),
    .o_pix_sof(o_pix_sof), .o_pix_eol(o_pix_eol), .o_pix_eof(o_pix_eof), .o_frame_cnt(o_frame_cnt),
    .o_frame_err(o_frame_err), .o_cfg_err(o_cfg_err), .o_state(o_state));

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [15:0] d);
    fifo_q.push_back(d);
    i_obuf_empty = 0;
  endtask

  // One clock: score the beat accepted at this edge, model the FIFO read latency, check holding.
  task automatic tick;
    bit rd, acc;
    #1;
    rd  = o_obuf_rd;
    acc = o_pix_valid && i_pix_ready;
    if (acc) begin
      check("beat_rate", 32'(prev_acc), 0);
      if (exp_q.size() == 0) check("extra_beat", 1, 0);
      else begin
        check("pix_data", 32'(o_pix_data), 32'(exp_q.pop_front()));
        check("pix_sof", 32'(o_pix_sof), 32'(pos == 0));
        check("pix_eol", 32'(o_pix_eol), 32'(pos % W == W - 1));
        check("pix_eof", 32'(o_pix_eof), 32'(pos == N - 1));
        pos = (pos + 1) % N;
        if (pos == 0) frames++;
      end
      beats++;
    end
    prev_acc  = acc;
    prev_hold = o_pix_valid && !i_pix_ready;
    prev_data = o_pix_data;
    @(posedge i_clk);
    #1;
    if (rd) begin
      if (fifo_q.size() == 0) check("rd_on_empty", 1, 0);
      else i_obuf_data = fifo_q.pop_front();
    end
    i_obuf_empty = fifo_q.size() == 0;
    #1;
    if (chk_hold && prev_hold) begin
      check("hold_valid", 32'(o_pix_valid), 1);
      check("hold_data", 32'(o_pix_data), 32'(prev_data));
    end
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_state"}, 32'(o_state), 0);
    check({tag, "_flags"}, 32'({o_cfg_init, o_obuf_rd, o_pix_valid, o_pix_sof, o_pix_eol, o_pix_eof, o_frame_err, o_cfg_err}), 0);
    check({tag, "_data"}, 32'(o_pix_data), 0);
    check({tag, "_fcnt"}, 32'(o_frame_cnt), 0);
  endtask

  task automatic do_reset;
    i_rstn = 0; i_cfg_done = 0; i_sof = 0; i_pix_ready = 0;
    fifo_q.delete(); exp_q.delete();
    i_obuf_empty = 1; pos = 0; frames = 0; prev_acc = 0; prev_hold = 0;
    repeat (2) @(posedge i_clk);
    #1;
    rst_checks("rst");
    @(negedge i_clk) i_rstn = 1;
  endtask

  task automatic cfg_ok;
    int t, first, pulses;
    t = 0; first = -1; pulses = 0;
    while (o_state != 3'd2 && t < 60) begin
      tick; t++;
      if (o_cfg_init) begin pulses++; if (first < 0) first = t; end
      if (first >= 0 && t == first + 5) i_cfg_done = 1;
    end
    check("cfg_first_pulse", 32'(first), 10);
    check("cfg_pulses", 32'(pulses), 1);
    check("cfg_done_lat", 32'(t), 32'(first + 6));
    check("cfg_state", 32'(o_state), 2);
    i_cfg_done = 0;
  endtask

  task automatic sof_pulse;
    i_sof = 1;
    repeat (3) tick;
    i_sof = 0;
    repeat (2) tick;
  endtask

  task automatic run_beats(input int n, input int budget);
    int b0, t;
    b0 = beats; t = 0;
    while (beats - b0 < n && t < budget) begin tick; t++; end
    check("beat_count", 32'(beats - b0), 32'(n));
  endtask

  initial begin
    int p[$];
    int t, err_t;
    logic [15:0] w[N];
    // configuration never completes: three attempts then ERROR
    do_reset;
    err_t = -1;
    for (t = 1; t <= 90; t++) begin
      tick;
      if (o_cfg_init) p.push_back(t);
      if (err_t < 0 && o_state == 3'd4) err_t = t;
    end
    check("fail_pulses", 32'(p.size()), 3);
    if (p.size() == 3) begin
      check("fail_p0", 32'(p[0]), 10);
      check("fail_gap1", 32'(p[1] - p[0]), 21);
      check("fail_gap2", 32'(p[2] - p[1]), 21);
    end
    check("fail_err_t", 32'(err_t), 73);
    check("fail_state", 32'(o_state), 4);
    check("fail_cfg_err", 32'(o_cfg_err), 1);

    do_reset;
    cfg_ok;

    // clean frame 1..8 with ready held high
    sof_pulse;
    check("f1_state", 32'(o_state), 3);
    for (int i = 1; i <= N; i++) begin push(16'(i)); exp_q.push_back(16'(i)); end
    i_pix_ready = 1;
    run_beats(N, 40);
    check("f1_fcnt", 32'(o_frame_cnt), 1);
    check("f1_model_fcnt", 32'(o_frame_cnt), 32'(frames));
    check("f1_state_end", 32'(o_state), 2);
    check("f1_err", 32'(o_frame_err), 0);

    // downstream stall mid-frame
    sof_pulse;
    for (int i = 1; i <= N; i++) begin push(16'(16'h0100 + i)); exp_q.push_back(16'(16'h0100 + i)); end
    i_pix_ready = 1;
    run_beats(2, 20);
    i_pix_ready = 0;
    repeat (5) begin
      tick;
      if (o_pix_valid) check("stall_rd", 32'(o_obuf_rd), 0);
    end
    check("stall_valid", 32'(o_pix_valid), 1);
    check("stall_data", 32'(o_pix_data), 16'h0103);
    i_pix_ready = 1;
    run_beats(N - 2, 40);
    check("f2_fcnt", 32'(o_frame_cnt), 2);

    // SOF arriving mid-frame restarts the frame
    sof_pulse;
    for (int i = 1; i <= N; i++) begin push(16'(16'h0200 + i)); exp_q.push_back(16'(16'h0200 + i)); end
    i_pix_ready = 1;
    run_beats(3, 20);
    i_pix_ready = 0;
    t = 0;
    while (!o_pix_valid && t < 5) begin tick; t++; end
    check("err_held", 32'(o_pix_data), 16'h0204);
    chk_hold = 0;
    sof_pulse;
    chk_hold = 1;
    check("err_flag", 32'(o_frame_err), 1);
    check("err_state", 32'(o_state), 3);
    check("err_fcnt", 32'(o_frame_cnt), 2);
    exp_q.delete();
    pos = 0;
    for (int i = 5; i <= N; i++) exp_q.push_back(16'(16'h0200 + i));
    for (int i = 9; i <= 12; i++) begin push(16'(16'h0200 + i)); exp_q.push_back(16'(16'h0200 + i)); end
    i_pix_ready = 1;
    run_beats(N, 40);
    check("err_fcnt_end", 32'(o_frame_cnt), 3);
    check("err_sticky", 32'(o_frame_err), 1);

    // random data, random FIFO pacing and random backpressure
    for (int f = 0; f < 6; f++) begin
      int pushed, fr0;
      pushed = 0; fr0 = frames; t = 0;
      sof_pulse;
      for (int i = 0; i < N; i++) begin w[i] = 16'($urandom); exp_q.push_back(w[i]); end
      while (frames == fr0 && t < 300) begin
        if (pushed < N && $urandom_range(0, 2) == 0) begin push(w[pushed]); pushed++; end
        i_pix_ready = $urandom_range(0, 3) != 0;
        tick; t++;
      end
      check("rnd_done", 32'(frames - fr0), 1);
      check("rnd_fcnt", 32'(o_frame_cnt), 32'(frames));
      check("rnd_state", 32'(o_state), 2);
    end

    // reset during STREAM clears outputs immediately
    sof_pulse;
    for (int i = 1; i <= N; i++) begin push(16'(16'h0300 + i)); exp_q.push_back(16'(16'h0300 + i)); end
    i_pix_ready = 1;
    run_beats(3, 20);
    tick;
    i_rstn = 0;
    #1;
    rst_checks("midrst");
    check("midrst_cfg_err", 32'(o_cfg_err), 0);
    do_reset;
    cfg_ok;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
